uart_tx_scheduler: RTL and testbench

//  Shares one UART transmitter between N_REQ packet sources (clock, sensor 1, sensor 2).

---
 rtl/uart_tx_scheduler_pkg.sv | 18 +
 rtl/uart_tx_scheduler_if.sv | 23 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 31 +++
 rtl/uart_tx_scheduler.sv | 129 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared UART constants, scheduler state encoding and packet-length helper.
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_e;

    // Tag byte, payload bytes, then an optional CR/LF pair.
    function automatic int pkt_len(input int pay_bytes, input int term_en);
        return 1 + pay_bytes + 2 * term_en;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Byte handshake between the scheduler (master) and the UART transmitter (slave).
interface uart_tx_scheduler_if;

    logic       oTx_Start;
    logic [7:0] oTx_Data;
    logic       iTx_Busy;
    logic       iTx_Done;

    modport master (
        output oTx_Start,
        output oTx_Data,
        input  iTx_Busy,
        input  iTx_Done
    );

    modport slave (
        input  oTx_Start,
        input  oTx_Data,
        output iTx_Busy,
        output iTx_Done
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request searching upward from ptr_i+1, wrapping.
// Zero latency; the caller advances the pointer to idx_o when it accepts the grant.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             vld_o,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        vld_o = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = PTR_W'((int'(ptr_i) + i) % N_REQ);
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shares one UART TX between N_REQ sources; grant 1 cycle after request, first byte 2 cycles.
// Each byte waits in SEND while the transmitter is busy and in WAIT until its done pulse.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int PAY_BYTES = 4,
    parameter int TERM_EN   = 1
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic [N_REQ-1:0]             iReq,
    input  logic [8*N_REQ-1:0]           iTag,
    input  logic [8*PAY_BYTES*N_REQ-1:0] iPayload,
    output logic [N_REQ-1:0]             oGrant,
    output logic                         oBusy,
    output logic                         oPkt_Done,
    uart_tx_scheduler_if.master          tx
);

    localparam int L     = pkt_len(PAY_BYTES, TERM_EN);
    localparam int IDX_W = $clog2(L);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [7:0]       pkt_q [L];
    logic [7:0]       pkt_d [L];
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             start_q, start_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;

    logic             arb_vld;
    logic [N_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0] arb_idx;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i (iReq),
        .ptr_i (ptr_q),
        .vld_o (arb_vld),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        pkt_d   = pkt_q;
        grant_d = '0;
        start_d = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_d  = arb_gnt;
                    ptr_d    = arb_idx;
                    idx_d    = '0;
                    state_d  = ST_SEND;
                    pkt_d[0] = iTag[8*int'(arb_idx) +: 8];
                    // Payload goes out most-significant byte first.
                    for (int b = 0; b < PAY_BYTES; b++) begin
                        pkt_d[1+b] = iPayload[8*(PAY_BYTES*int'(arb_idx) + PAY_BYTES-1-b) +: 8];
                    end
                    if (TERM_EN != 0) begin
                        pkt_d[L-2] = ASCII_CR;
                        pkt_d[L-1] = ASCII_LF;
                    end
                end
            end
            ST_SEND: begin
                if (!tx.iTx_Busy) begin
                    start_d = 1'b1;
                    data_d  = pkt_q[idx_q];
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx.iTx_Done) begin
                    if (idx_q == IDX_W'(L-1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= PTR_W'(N_REQ-1);
            grant_q <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < L; i++) begin
                pkt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            start_q <= start_d;
            data_q  <= data_d;
            done_q  <= done_d;
            pkt_q   <= pkt_d;
        end
    end

    assign oGrant       = grant_q;
    assign oPkt_Done    = done_q;
    assign oBusy        = (state_q != ST_IDLE);
    assign tx.oTx_Start = start_q;
    assign tx.oTx_Data  = data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: instance A (3 req, 4 payload bytes, CR/LF) and instance B (3 req, 2 bytes, no terminator).
module tb_uart_tx_scheduler;

    logic iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic        iRst;
    logic [2:0]  a_req, b_req;
    logic [31:0] pay0, pay1, pay2;
    logic [23:0] a_tag, b_tag;
    logic [95:0] a_payload;
    logic [47:0] b_payload;
    logic [2:0]  a_grant, b_grant;
    logic        a_busy_o, a_pdone, b_busy_o, b_pdone;

    assign a_payload = {pay2, pay1, pay0};

    uart_tx_scheduler_if a_if ();
    uart_tx_scheduler_if b_if ();

    uart_tx_scheduler #(.N_REQ(3), .PAY_BYTES(4), .TERM_EN(1)) dut_a (
        .iClk      (iClk),
        .iRst      (iRst),
        .iReq      (a_req),
        .iTag      (a_tag),
        .iPayload  (a_payload),
        .oGrant    (a_grant),
        .oBusy     (a_busy_o),
        .oPkt_Done (a_pdone),
        .tx        (a_if)
    );

    uart_tx_scheduler #(.N_REQ(3), .PAY_BYTES(2), .TERM_EN(0)) dut_b (
        .iClk      (iClk),
        .iRst      (iRst),
        .iReq      (b_req),
        .iTag      (b_tag),
        .iPayload  (b_payload),
        .oGrant    (b_grant),
        .oBusy     (b_busy_o),
        .oPkt_Done (b_pdone),
        .tx        (b_if)
    );

    int checks = 0;
    int failures = 0;
    int a_pdone_cnt = 0;
    int b_pdone_cnt = 0;
    int b_start_cnt = 0;
    int a_viol = 0;
    int b_viol = 0;
    logic a_busy_e, b_busy_e;
    int a_glog[$];
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  exp_grant;
        logic [7:0]  exp_tag;
        logic [31:0] exp_pay;
    } vec_t;
    vec_t vecs[6];

    always @(posedge iClk) begin
        a_busy_e <= a_if.iTx_Busy;
        b_busy_e <= b_if.iTx_Busy;
    end

    always @(negedge iClk) begin
        if (a_pdone) a_pdone_cnt <= a_pdone_cnt + 1;
        if (b_pdone) b_pdone_cnt <= b_pdone_cnt + 1;
        if (b_if.oTx_Start) b_start_cnt <= b_start_cnt + 1;
        if (a_if.oTx_Start && a_busy_e) a_viol <= a_viol + 1;
        if (b_if.oTx_Start && b_busy_e) b_viol <= b_viol + 1;
        for (int k = 0; k < 3; k++) begin
            if (a_grant[k]) a_glog.push_back(k);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge iClk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_busy(input int sel, input logic v);
        if (sel == 1) b_if.iTx_Busy = v;
        else          a_if.iTx_Busy = v;
    endtask

    task automatic set_done(input int sel, input logic v);
        if (sel == 1) b_if.iTx_Done = v;
        else          a_if.iTx_Done = v;
    endtask

    task automatic wait_start(input int sel, output logic [7:0] b, output logic seen);
        seen = 1'b0;
        b    = 8'h00;
        for (int c = 0; c < 60 && !seen; c++) begin
            tick();
            if ((sel == 1) ? b_if.oTx_Start : a_if.oTx_Start) begin
                seen = 1'b1;
                b    = (sel == 1) ? b_if.oTx_Data : a_if.oTx_Data;
            end
        end
        check("start_seen", {31'b0, seen}, 32'd1);
    endtask

    // Transmitter response: busy for 'delay' cycles, then a one-cycle done pulse.
    task automatic ack(input int sel, input int delay);
        set_busy(sel, 1'b1);
        repeat (delay) tick();
        set_done(sel, 1'b1);
        set_busy(sel, 1'b0);
        tick();
        set_done(sel, 1'b0);
    endtask

    task automatic serve(input int sel, input int n, input int delay);
        logic [7:0] b;
        logic       seen;
        for (int i = 0; i < n; i++) begin
            wait_start(sel, b, seen);
            if (!seen) return;
            obs_q.push_back(b);
            ack(sel, delay);
        end
    endtask

    task automatic build(input logic [7:0] tag, input logic [31:0] pay, input int nbytes, input bit term);
        exp_q.delete();
        exp_q.push_back(tag);
        for (int b = nbytes - 1; b >= 0; b--) exp_q.push_back(pay[8*b +: 8]);
        if (term) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic check_bytes(input string name);
        check({name, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), obs_q[i], exp_q[i]);
        end
    endtask

    initial begin
        int cnt;
        int pd;
        iRst  = 1'b1;
        a_req = '0;
        b_req = '0;
        pay0  = 32'h3132_3334;
        pay1  = 32'hAAAA_AAAA;
        pay2  = 32'hDEAD_BEEF;
        a_tag = {8'h42, 8'h41, 8'h54};
        b_tag = {8'h42, 8'h41, 8'h54};
        b_payload = {16'hBEEF, 16'h0000, 16'h3132};
        a_if.iTx_Busy = 1'b0;
        a_if.iTx_Done = 1'b0;
        b_if.iTx_Busy = 1'b0;
        b_if.iTx_Done = 1'b0;

        // Pointer starts at 2, so arbitration order follows from the previous winner.
        vecs[0] = '{3'b001, 3'b001, 8'h54, 32'h3132_3334};
        vecs[1] = '{3'b011, 3'b010, 8'h41, 32'hAAAA_AAAA};
        vecs[2] = '{3'b011, 3'b001, 8'h54, 32'h3132_3334};
        vecs[3] = '{3'b101, 3'b100, 8'h42, 32'hDEAD_BEEF};
        vecs[4] = '{3'b100, 3'b100, 8'h42, 32'hDEAD_BEEF};
        vecs[5] = '{3'b110, 3'b010, 8'h41, 32'hAAAA_AAAA};

        repeat (2) tick();
        check("rst_grant", a_grant, 3'b000);
        check("rst_start", a_if.oTx_Start, 1'b0);
        check("rst_data", a_if.oTx_Data, 8'h00);
        check("rst_busy", a_busy_o, 1'b0);
        check("rst_pdone", a_pdone, 1'b0);
        check("rst_b_start", b_if.oTx_Start, 1'b0);
        check("rst_b_busy", b_busy_o, 1'b0);
        iRst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            a_req = vecs[i].req;
            tick();
            check($sformatf("vec%0d_grant", i), a_grant, vecs[i].exp_grant);
            a_req = '0;
            obs_q.delete();
            serve(0, 7, 1 + (i % 3));
            build(vecs[i].exp_tag, vecs[i].exp_pay, 4, 1'b1);
            check_bytes($sformatf("vec%0d", i));
            check($sformatf("vec%0d_pdone", i), a_pdone, 1'b1);
            check($sformatf("vec%0d_idle", i), a_busy_o, 1'b0);
        end
        tick();
        check("table_pdone_cnt", a_pdone_cnt, 6);

        // Busy guard: transmitter busy for 20 cycles while the scheduler sits in SEND.
        begin
            logic [7:0] b;
            logic       seen;
            a_if.iTx_Busy = 1'b1;
            a_req = 3'b001;
            tick();
            check("busy_grant", a_grant, 3'b001);
            a_req = '0;
            cnt = 0;
            repeat (20) begin
                tick();
                if (a_if.oTx_Start) cnt++;
            end
            check("busy_no_start", cnt, 0);
            check("busy_in_send", a_busy_o, 1'b1);
            a_if.iTx_Busy = 1'b0;
            wait_start(0, b, seen);
            check("busy_first_byte", b, 8'h54);
            tick();
            check("busy_single_pulse", a_if.oTx_Start, 1'b0);
            ack(0, 1);
            obs_q.delete();
            serve(0, 6, 1);
            exp_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
            check_bytes("busy_rest");
            check("busy_pdone", a_pdone, 1'b1);
        end

        // Payload of source 1 changes right after its grant; the latched packet must not.
        a_req = 3'b010;
        tick();
        check("chg_grant", a_grant, 3'b010);
        a_req = '0;
        pay1  = 32'h5555_5555;
        obs_q.delete();
        serve(0, 7, 1);
        build(8'h41, 32'hAAAA_AAAA, 4, 1'b1);
        check_bytes("chg");

        // Reset after the third done: packet aborted, pointer back to 2.
        a_req = 3'b010;
        tick();
        check("abort_grant", a_grant, 3'b010);
        a_req = '0;
        obs_q.delete();
        serve(0, 3, 1);
        build(8'h41, 32'h5555_5555, 4, 1'b1);
        exp_q = exp_q[0:2];
        check_bytes("abort");
        pd = a_pdone_cnt;
        iRst = 1'b1;
        tick();
        check("abort_rst_grant", a_grant, 3'b000);
        check("abort_rst_start", a_if.oTx_Start, 1'b0);
        check("abort_rst_data", a_if.oTx_Data, 8'h00);
        check("abort_rst_busy", a_busy_o, 1'b0);
        check("abort_rst_pdone", a_pdone, 1'b0);
        iRst = 1'b0;
        a_if.iTx_Done = 1'b1;
        tick();
        a_if.iTx_Done = 1'b0;
        cnt = 0;
        repeat (6) begin
            tick();
            if (a_if.oTx_Start || a_pdone || a_busy_o) cnt++;
        end
        check("abort_quiet", cnt, 0);
        check("abort_no_pdone", a_pdone_cnt, pd);
        a_req = 3'b110;
        tick();
        check("abort_next_grant", a_grant, 3'b010);
        a_req = '0;
        obs_q.delete();
        serve(0, 7, 1);
        check("abort_next_pdone", a_pdone, 1'b1);
        tick();
        check("a_pdone_cnt", a_pdone_cnt, 9);

        // Round-robin with all three requesting continuously.
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        a_glog.delete();
        a_req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            obs_q.delete();
            serve(0, 7, 1);
            check($sformatf("rr%0d_pdone", k), a_pdone, 1'b1);
            if (k < 5) begin
                tick();
                check($sformatf("rr%0d_b2b_grant", k), {29'b0, a_grant}, 32'd1 << ((k + 1) % 3));
            end
        end
        a_req = '0;
        tick();
        check("rr_count", a_glog.size(), 6);
        for (int k = 0; k < 6 && k < a_glog.size(); k++) begin
            check($sformatf("rr_order%0d", k), a_glog[k], k % 3);
        end

        // Short packet, no terminator, with a stray done while idle.
        b_if.iTx_Done = 1'b1;
        tick();
        b_if.iTx_Done = 1'b0;
        repeat (5) tick();
        check("b_stray_starts", b_start_cnt, 0);
        check("b_stray_pdone", b_pdone_cnt, 0);
        check("b_stray_busy", b_busy_o, 1'b0);
        b_req = 3'b001;
        tick();
        check("b_grant0", b_grant, 3'b001);
        b_req = '0;
        obs_q.delete();
        serve(1, 3, 2);
        build(8'h54, 32'h0000_3132, 2, 1'b0);
        check_bytes("b_pkt0");
        check("b_pdone0", b_pdone, 1'b1);
        b_req = 3'b100;
        tick();
        check("b_grant1", b_grant, 3'b100);
        b_req = '0;
        obs_q.delete();
        serve(1, 3, 1);
        build(8'h42, 32'h0000_BEEF, 2, 1'b0);
        check_bytes("b_pkt1");
        repeat (4) tick();
        check("b_start_cnt", b_start_cnt, 6);
        check("b_pdone_cnt", b_pdone_cnt, 2);
        check("a_busy_violation", a_viol, 0);
        check("b_busy_violation", b_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
